// File: rtl/ps2_kbd_receiver.sv
`default_nettype none
// ps2_kbd_receiver -- PS/2 device-to-host receiver: sync, clock deglitch, 11-bit frame check, E0/F0 key decode.
// rev 1.0
module ps2_kbd_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] oByte,
  output logic       oByteValid,
  output logic [7:0] oKey,
  output logic       oExtended,
  output logic       oRelease,
  output logic       oKeyValid,
  output logic       oParityErr,
  output logic       oFrameErr,
  output logic       oBusy
);

  localparam int            c_tmo_w    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                  r_clk_s1, r_clk_s2;
  logic                  r_dat_s1, r_dat_s2;
  logic [FILTER_LEN-1:0] r_filt_sr;
  logic                  r_filt_clk;
  logic                  w_fall;

  state_t                r_state;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_shift;
  logic                  r_par;
  logic [c_tmo_w-1:0]    r_tmo;
  logic                  r_ext;
  logic                  r_rel;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_sr  <= '1;
      r_filt_clk <= 1'b1;
    end else begin
      r_clk_s1  <= PS2_CLK;
      r_clk_s2  <= r_clk_s1;
      r_dat_s1  <= PS2_DATA;
      r_dat_s2  <= r_dat_s1;
      r_filt_sr <= {r_filt_sr[FILTER_LEN-2:0], r_clk_s2};
      if (r_filt_sr == '0)
        r_filt_clk <= 1'b0;
      else if (&r_filt_sr)
        r_filt_clk <= 1'b1;
    end
  end

  // The filtered clock drops on the same edge this strobe is seen, so it is exactly one cycle wide.
  assign w_fall = r_filt_clk && (r_filt_sr == '0);
  assign oBusy  = (r_state != S_IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tmo      <= '0;
      r_ext      <= 1'b0;
      r_rel      <= 1'b0;
      oByte      <= '0;
      oByteValid <= 1'b0;
      oKey       <= '0;
      oExtended  <= 1'b0;
      oRelease   <= 1'b0;
      oKeyValid  <= 1'b0;
      oParityErr <= 1'b0;
      oFrameErr  <= 1'b0;
    end else begin
      oByteValid <= 1'b0;
      oKeyValid  <= 1'b0;
      oParityErr <= 1'b0;
      oFrameErr  <= 1'b0;

      if (w_fall || r_state == S_IDLE)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + c_tmo_w'(1);

      if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end else begin
              oFrameErr <= 1'b1;
              r_ext     <= 1'b0;
              r_rel     <= 1'b0;
            end
          end
          S_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
              r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!r_dat_s2) begin
              oFrameErr <= 1'b1;
              r_ext     <= 1'b0;
              r_rel     <= 1'b0;
            end else if (^{r_shift, r_par} == 1'b0) begin
              oParityErr <= 1'b1;
              r_ext      <= 1'b0;
              r_rel      <= 1'b0;
            end else begin
              oByte      <= r_shift;
              oByteValid <= 1'b1;
              if (r_shift == 8'hE0)
                r_ext <= 1'b1;
              else if (r_shift == 8'hF0)
                r_rel <= 1'b1;
              else begin
                oKey      <= r_shift;
                oExtended <= r_ext;
                oRelease  <= r_rel;
                oKeyValid <= 1'b1;
                r_ext     <= 1'b0;
                r_rel     <= 1'b0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE && r_tmo == c_tmo_last) begin
        r_state   <= S_IDLE;
        oFrameErr <= 1'b1;
        r_ext     <= 1'b0;
        r_rel     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_receiver.sv
`default_nettype none
// tb_ps2_kbd_receiver -- drives PS/2 frames and checks pulses against an event-queue model of the receiver.
// rev 1.0
module tb_ps2_kbd_receiver;

  localparam int FL   = 8;
  localparam int TMO  = 500;
  localparam int HALF = 40;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c  = 1'b1;
  logic       ps2d  = 1'b1;
  logic [7:0] oByte, oKey;
  logic       oByteValid, oExtended, oRelease, oKeyValid, oParityErr, oFrameErr, oBusy;

  ps2_kbd_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(clk), .Reset(rst_n), .PS2_CLK(ps2c), .PS2_DATA(ps2d),
    .oByte(oByte), .oByteValid(oByteValid), .oKey(oKey), .oExtended(oExtended),
    .oRelease(oRelease), .oKeyValid(oKeyValid), .oParityErr(oParityErr),
    .oFrameErr(oFrameErr), .oBusy(oBusy)
  );

  always #10 clk = ~clk;

  typedef struct { int kind; logic [7:0] b; } ev_t;            // kind: 0 byte, 1 parity, 2 frame
  typedef struct { logic [7:0] k; logic e; logic r; } key_t;

  ev_t  exp_ev[$];
  key_t exp_key[$];
  bit   m_ext, m_rel;
  int   n_tests = 0, n_fail = 0;
  int   cnt_bv = 0, cnt_kv = 0, cnt_pe = 0, cnt_fe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of one complete frame with a good stop bit; p is the transmitted parity bit.
  task automatic model_frame(input logic [7:0] b, input logic p);
    ev_t  e;
    key_t k;
    if (^{b, p} == 1'b0) begin
      e.kind = 1; e.b = 8'h00; exp_ev.push_back(e);
      m_ext = 0; m_rel = 0;
    end else begin
      e.kind = 0; e.b = b; exp_ev.push_back(e);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else begin
        k.k = b; k.e = m_ext; k.r = m_rel; exp_key.push_back(k);
        m_ext = 0; m_rel = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t  e;
    key_t k;
    int   kind;
    if (rst_n) begin
      if (oByteValid | oParityErr | oFrameErr) begin
        check("pulse_exclusive", 32'(int'(oByteValid) + int'(oParityErr) + int'(oFrameErr)), 32'd1);
        kind = oByteValid ? 0 : (oParityErr ? 1 : 2);
        if (exp_ev.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
        end else begin
          e = exp_ev.pop_front();
          check("pulse_kind", 32'(kind), 32'(e.kind));
          if (e.kind == 0 && kind == 0) check("byte_value", 32'(oByte), 32'(e.b));
        end
      end
      if (oKeyValid) begin
        if (exp_key.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_key: got 0x%0h expected none", oKey);
        end else begin
          k = exp_key.pop_front();
          check("key_code", 32'(oKey), 32'(k.k));
          check("key_ext", 32'(oExtended), 32'(k.e));
          check("key_rel", 32'(oRelease), 32'(k.r));
        end
      end
      if (oByteValid) cnt_bv++;
      if (oKeyValid)  cnt_kv++;
      if (oParityErr) cnt_pe++;
      if (oFrameErr)  cnt_fe++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    ps2d = v;
    if (glitch) begin
      cyc(10); ps2c = 1'b0; cyc(FL - 2); ps2c = 1'b1; cyc(HALF - 10 - (FL - 2));
    end else begin
      cyc(HALF);
    end
    ps2c = 1'b0; cyc(HALF); ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic [10:0] bits;
    logic        p;
    p = ~^b;
    if (bad_par) p = ~p;
    bits = {1'b1, p, b, 1'b0};
    model_frame(b, p);
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch && (i == 3 || i == 6));
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], 1'b0);
    ps2d = 1'b1;
  endtask

  task automatic drained(input string name);
    cyc(20);
    check({name, "_ev_left"}, 32'(exp_ev.size()), 32'd0);
    check({name, "_key_left"}, 32'(exp_key.size()), 32'd0);
  endtask

  initial begin
    int bv0, kv0, pe0, fe0;
    ev_t e;

    #50;
    check("reset_outputs", {oByte, oKey, oByteValid, oExtended, oRelease, oKeyValid,
                            oParityErr, oFrameErr, oBusy}, 32'd0);
    #50 rst_n = 1'b1;
    cyc(2000);
    check("idle_outputs", {oByte, oKey, oBusy}, 32'd0);
    check("idle_pulses", 32'(cnt_bv + cnt_kv + cnt_pe + cnt_fe), 32'd0);

    // single make code
    send_frame(8'h1C, 0, 0);
    drained("make_1c");
    check("1c_byte", 32'(oByte), 32'h1C);
    check("1c_key", {oKey, oExtended, oRelease}, {22'd0, 8'h1C, 2'b00});
    check("1c_counts", 32'(cnt_bv * 16 + cnt_kv), 32'h11);

    // break and extended-break sequences
    bv0 = cnt_bv; kv0 = cnt_kv;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check("f0_1c_key", {oKey, oExtended, oRelease}, {22'd0, 8'h1C, 2'b01});
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    drained("ext_break");
    check("e0f0_75_key", {oKey, oExtended, oRelease}, {22'd0, 8'h75, 2'b11});
    check("seq_byte_pulses", 32'(cnt_bv - bv0), 32'd5);
    check("seq_key_pulses", 32'(cnt_kv - kv0), 32'd2);

    // parity error after a pending F0 clears the prefix
    pe0 = cnt_pe; bv0 = cnt_bv;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 0);
    cyc(5);
    check("perr_byte_hold", 32'(oByte), 32'hF0);
    check("perr_key_hold", 32'(oKey), 32'h75);
    send_frame(8'h29, 0, 0);
    drained("parity");
    check("perr_count", 32'(cnt_pe - pe0), 32'd1);
    check("perr_good_bytes", 32'(cnt_bv - bv0), 32'd2);
    check("after_perr_key", {oKey, oExtended, oRelease}, {22'd0, 8'h29, 2'b00});

    // truncated frame times out
    fe0 = cnt_fe;
    e.kind = 2; e.b = 8'h00; exp_ev.push_back(e);
    m_ext = 0; m_rel = 0;
    send_partial(8'h29, 5);
    check("partial_busy", 32'(oBusy), 32'd1);
    cyc(TMO + 10);
    check("timeout_ferr", 32'(cnt_fe - fe0), 32'd1);
    check("timeout_idle", 32'(oBusy), 32'd0);
    bv0 = cnt_bv;
    send_frame(8'h29, 0, 0);
    drained("timeout");
    check("after_tmo_byte", 32'(oByte), 32'h29);
    check("after_tmo_bv", 32'(cnt_bv - bv0), 32'd1);

    // short clock glitches inside a frame
    bv0 = cnt_bv;
    send_frame(8'h5A, 0, 1);
    drained("glitch");
    check("glitch_byte", 32'(oByte), 32'h5A);
    check("glitch_bv", 32'(cnt_bv - bv0), 32'd1);

    // reset in the middle of a frame
    bv0 = cnt_bv; pe0 = cnt_pe; fe0 = cnt_fe;
    send_partial(8'h33, 6);
    rst_n = 1'b0;
    m_ext = 0; m_rel = 0;
    cyc(5);
    check("midreset_outputs", {oByte, oKey, oBusy, oByteValid, oKeyValid}, 32'd0);
    rst_n = 1'b1;
    cyc(50);
    check("midreset_no_pulses", 32'((cnt_bv - bv0) + (cnt_pe - pe0) + (cnt_fe - fe0)), 32'd0);
    send_frame(8'h1C, 0, 0);
    drained("post_reset");
    check("post_reset_key", {oKey, oExtended, oRelease}, {22'd0, 8'h1C, 2'b00});
    check("post_reset_byte", 32'(oByte), 32'h1C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
